// File: rtl/sync_fifo_drain.sv
// -----------------------------------------------------------------------------
// sync_fifo_drain
//
// Read-side controller for sync_fifo. A start command drains exactly
// burst_len words from the FIFO and presents them on a valid/ready stream.
// The FIFO's level-based empty/rd_en interface has one cycle of read latency.
// A 2-entry output buffer absorbs that latency so one word per cycle can be
// sustained.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous, active-low reset
//   start          - one-cycle command pulse, sampled only while idle
//   burst_len      - number of words to drain, latched on an accepted start
//   fifo_empty     - FIFO empty flag
//   fifo_read_data - FIFO read data, valid the cycle after a sampled rd_en
//   fifo_rd_en     - FIFO read enable (combinational)
//   out_valid      - output word valid
//   out_ready      - downstream accepts the word
//   out_data       - output word (head of the buffer)
//   busy           - burst in progress (READ or DRAIN)
//   done           - one-cycle pulse when a burst completes
//   xfer_count     - words accepted downstream in the current burst
// -----------------------------------------------------------------------------
module sync_fifo_drain #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_read_data,
   output logic             fifo_rd_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] xfer_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] issued_q, issued_d;
   logic [LEN_W-1:0] xfer_q, xfer_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       occ_q, occ_d;
   logic [WIDTH-1:0] buf_q [2];
   logic [WIDTH-1:0] buf_d [2];
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             pop;
   logic             last_pop;
   logic             room;

   assign out_valid  = (occ_q != 2'd0);
   assign out_data   = buf_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign xfer_count = xfer_q;

   assign pop = out_valid & out_ready;

   // Space check counts the word already in flight from the FIFO, and credits
   // the entry being popped this cycle so back-to-back reads keep flowing.
   assign room = (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

   assign fifo_rd_en = (state_q == READ) & ~fifo_empty & (issued_q < len_q) & room;

   // The final word of the burst leaves the buffer this cycle.
   assign last_pop = pop & (state_q != IDLE) & ((xfer_q + LEN_W'(1)) == len_q);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      issued_d   = issued_q + LEN_W'(fifo_rd_en);
      xfer_d     = xfer_q + LEN_W'(pop);
      inflight_d = fifo_rd_en;
      done_d     = 1'b0;

      // Buffer: pop shifts the tail into the head, then the word returned by
      // the previous read lands in the first free slot, preserving order.
      buf_d = buf_q;
      occ_d = occ_q;
      if (pop) begin
         buf_d[0] = buf_q[1];
         occ_d    = occ_q - 2'd1;
      end
      if (inflight_q) begin
         if (occ_d == 2'd0) begin
            buf_d[0] = fifo_read_data;
         end else begin
            buf_d[1] = fifo_read_data;
         end
         occ_d = occ_d + 2'd1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d    = burst_len;
               issued_d = '0;
               xfer_d   = '0;
               if (burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (last_pop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (issued_d == len_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_pop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         xfer_q     <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         xfer_q     <= xfer_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         buf_q      <= buf_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_drain
//
// Directed and randomized bench for sync_fifo_drain. The FIFO is modelled as a
// queue with one cycle of read latency. Expected behaviour comes from the
// burst rules: delivered words equal FIFO pops in order, a burst delivers
// exactly its length, done follows the last accepted word, stalled words stay
// put, and no more than two words are ever outstanding.
// -----------------------------------------------------------------------------
module tb_sync_fifo_drain;
   localparam int WIDTH = 8;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [LEN_W-1:0] burst_len;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_read_data;
   logic             fifo_rd_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] xfer_count;

   always #5 clk = ~clk;

   sync_fifo_drain #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .burst_len      (burst_len),
      .fifo_empty     (fifo_empty),
      .fifo_read_data (fifo_read_data),
      .fifo_rd_en     (fifo_rd_en),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .busy           (busy),
      .done           (done),
      .xfer_count     (xfer_count)
   );

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] fifo_q[$];   // FIFO contents
   logic [WIDTH-1:0] pend[$];     // words popped from the FIFO, not yet delivered
   bit   m_busy = 0;
   bit   m_done = 0;
   int   m_len = 0;
   int   m_pops = 0;
   int   m_reads = 0;
   int   done_cnt = 0;
   int   pop_total = 0;
   bit   hold_valid = 0;
   logic [WIDTH-1:0] hold_data = '0;
   bit   ready_rand = 0;
   int   wr_left = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic fifo_clear();
      fifo_q.delete();
      fifo_empty = 1'b1;
   endtask

   // One clock cycle: called at a falling edge with inputs applied, returns at
   // the next falling edge.
   task automatic cycle();
      bit rd, pp, acc;
      logic [WIDTH-1:0] d, w;
      if (ready_rand) out_ready = 1'($urandom_range(0, 1));
      #1;
      rd = fifo_rd_en;
      pp = out_valid && out_ready;
      d  = out_data;
      if (hold_valid) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", d, hold_data);
      end
      if (rd) begin
         chk("rd_while_empty", fifo_empty, 0);
         chk("rd_while_not_busy", m_busy, 1);
         chk("rd_beyond_len", m_reads < m_len, 1);
      end
      if (pp) begin
         chk("pop_has_word", pend.size() > 0, 1);
         if (pend.size() > 0) begin
            w = pend.pop_front();
            chk("out_data", d, w);
         end
      end
      acc = start && !m_busy;
      hold_valid = out_valid && !out_ready;
      hold_data = d;

      @(posedge clk);
      #1;
      m_done = 0;
      if (reset) begin
         if (acc) begin
            m_len = int'(burst_len);
            m_pops = 0;
            m_reads = 0;
            if (burst_len == '0) m_done = 1;
            else m_busy = 1;
         end else if (m_busy) begin
            if (rd) m_reads++;
            if (pp) begin
               m_pops++;
               if (m_pops == m_len) begin
                  chk("reads_at_done", m_reads, m_len);
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end
      end
      if (pp) pop_total++;
      if (rd) begin
         chk("fifo_underflow", fifo_q.size() > 0, 1);
         if (fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            pend.push_back(w);
            fifo_read_data = w;
         end
      end
      if (wr_left > 0 && $urandom_range(0, 1) == 1) begin
         fifo_q.push_back(8'($urandom));
         wr_left--;
      end
      fifo_empty = (fifo_q.size() == 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("xfer_count", xfer_count, m_pops);
      chk("outstanding_le2", pend.size() <= 2, 1);
      if (done) done_cnt++;
      @(negedge clk);
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, done_cnt - d0, 1);
   endtask

   initial begin
      int n, d0, p0, k, len, q0;
      reset = 1'b0;
      start = 1'b0;
      burst_len = '0;
      out_ready = 1'b0;
      fifo_empty = 1'b1;
      fifo_read_data = '0;
      #2;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_xfer_count", xfer_count, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Full-rate burst of 16 words
      for (int i = 0; i < 16; i++) push_word(8'(i));
      out_ready = 1'b1;
      start = 1'b1;
      burst_len = 8'd16;
      cycle();
      start = 1'b0;
      n = 0;
      while (!out_valid && n < 8) begin
         cycle();
         n++;
      end
      chk("t1_first_valid_latency", n, 2);
      p0 = pop_total;
      for (int i = 0; i < 16; i++) begin
         chk("t1_stream_valid", out_valid, 1);
         cycle();
      end
      chk("t1_words", pop_total - p0, 16);
      chk("t1_done_count", done_cnt, 1);
      chk("t1_xfer_final", xfer_count, 16);
      chk("t1_fifo_left", fifo_q.size(), 0);
      cycle();
      cycle();

      // Back-pressure 1,0,0 pattern, burst of 8
      fifo_clear();
      for (int i = 0; i < 16; i++) push_word(8'(i));
      start = 1'b1;
      burst_len = 8'd8;
      out_ready = 1'b1;
      cycle();
      start = 1'b0;
      d0 = done_cnt;
      p0 = pop_total;
      k = 0;
      while (done_cnt == d0 && k < 100) begin
         out_ready = (k % 3 == 0);
         cycle();
         k++;
      end
      chk("t2_done", done_cnt - d0, 1);
      chk("t2_words", pop_total - p0, 8);
      chk("t2_fifo_left", fifo_q.size(), 8);

      // Starvation: empty FIFO, words trickle in every third cycle
      fifo_clear();
      out_ready = 1'b1;
      start = 1'b1;
      burst_len = 8'd4;
      cycle();
      start = 1'b0;
      p0 = pop_total;
      for (int i = 0; i < 5; i++) begin
         chk("t3_rd_idle", fifo_rd_en, 0);
         chk("t3_busy", busy, 1);
         cycle();
      end
      for (int i = 0; i < 4; i++) begin
         push_word(8'hA1 + 8'(i));
         cycle();
         cycle();
         cycle();
      end
      if (m_busy) run_until_done(20, "t3_done");
      chk("t3_words", pop_total - p0, 4);
      chk("t3_idle_after", busy, 0);

      // Zero-length burst
      cycle();
      start = 1'b1;
      burst_len = 8'd0;
      cycle();
      start = 1'b0;
      chk("t4_done", done, 1);
      chk("t4_busy", busy, 0);
      cycle();
      chk("t4_done_clear", done, 0);

      // Second start during a 10-word burst is ignored
      fifo_clear();
      for (int i = 0; i < 10; i++) push_word(8'h30 + 8'(i));
      d0 = done_cnt;
      p0 = pop_total;
      start = 1'b1;
      burst_len = 8'd10;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      start = 1'b1;
      burst_len = 8'd3;
      cycle();
      start = 1'b0;
      run_until_done(100, "t5_done");
      for (int i = 0; i < 4; i++) cycle();
      chk("t5_words", pop_total - p0, 10);
      chk("t5_single_done", done_cnt - d0, 1);

      // Reset mid-burst, then a short burst takes the next FIFO words
      fifo_clear();
      for (int i = 0; i < 12; i++) push_word(8'h50 + 8'(i));
      p0 = pop_total;
      start = 1'b1;
      burst_len = 8'd10;
      cycle();
      start = 1'b0;
      n = 0;
      while (pop_total - p0 < 5 && n < 50) begin
         cycle();
         n++;
      end
      chk("t6_five_words", pop_total - p0, 5);
      d0 = done_cnt;
      reset = 1'b0;
      #1;
      chk("t6_rst_rd_en", fifo_rd_en, 0);
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_out_data", out_data, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_xfer_count", xfer_count, 0);
      m_busy = 0;
      m_done = 0;
      m_pops = 0;
      m_reads = 0;
      m_len = 0;
      pend.delete();
      hold_valid = 0;
      cycle();
      reset = 1'b1;
      cycle();
      chk("t6_no_done_after_reset", done_cnt - d0, 0);
      q0 = fifo_q.size();
      p0 = pop_total;
      start = 1'b1;
      burst_len = 8'd2;
      cycle();
      start = 1'b0;
      run_until_done(20, "t6_done");
      chk("t6_words", pop_total - p0, 2);
      chk("t6_fifo_used", q0 - fifo_q.size(), 2);

      // Randomized bursts: random lengths, random ready, random FIFO writes
      fifo_clear();
      for (int b = 0; b < 6; b++) begin
         len = $urandom_range(1, 20);
         wr_left = len + $urandom_range(0, 3);
         ready_rand = 1;
         p0 = pop_total;
         start = 1'b1;
         burst_len = 8'(len);
         cycle();
         start = 1'b0;
         run_until_done(600, "rand_done");
         chk("rand_words", pop_total - p0, len);
         ready_rand = 0;
         out_ready = 1'b1;
         wr_left = 0;
         cycle();
         fifo_clear();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
